serial_tx_arbiter: RTL and testbench

- Shares one byte-wide UART transmit channel among NUM_PORTS requesters.
- Round-robin arbitration at message granularity: the winning port keeps ownership until its byte marked last is accepted, so messages never interleave.
- Holds a one-byte prefetch buffer, so the owner's next byte is fetched while the transmitter shifts the current one.
- Sits between debug/status producers and the serial_transmitter; drives its tx_data / tx_data_available and observes its tx_ready.

---
 rtl/serial_tx_arbiter.sv | 160 ++++++++++++++++
 tb/tb_serial_tx_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx_arbiter
//  Purpose  : Shares one byte-wide UART transmit channel among NUM_PORTS
//             requesters. Round-robin arbitration at message granularity,
//             with a one-byte prefetch buffer and an idle-owner timeout.
//  Revision : 1.0  initial release
// ============================================================================
module serial_tx_arbiter #(
  parameter int NUM_PORTS    = 4,
  parameter int HOLD_TIMEOUT = 50000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_PORTS*8-1:0]       req_data,
  input  logic [NUM_PORTS-1:0]         req_valid,
  input  logic [NUM_PORTS-1:0]         req_last,
  output logic [NUM_PORTS-1:0]         req_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_data_available,
  input  logic                         tx_ready,
  output logic [$clog2(NUM_PORTS)-1:0] grant_id,
  output logic                         busy,
  output logic                         lock_timeout
);

  localparam int          IDW        = $clog2(NUM_PORTS);
  localparam logic [15:0] TCNT_LAST  = 16'(HOLD_TIMEOUT - 1);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_NEXT = 2'd2
  } state_t;

  state_t         state_q;
  logic [7:0]     buf_data_q;
  logic           buf_last_q;
  logic [IDW-1:0] grant_q;
  logic [IDW-1:0] rr_q;
  logic [15:0]    tcnt_q;
  logic           lock_timeout_q;

  logic [7:0]     port_byte [NUM_PORTS];
  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] rr_d;

  // Unpack the flat request bus into one byte per port.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign port_byte[p] = req_data[8*p +: 8];
  end

  // Round-robin search: first valid port starting at rr_q, wrapping modulo NUM_PORTS.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_PORTS) begin
        idx = idx - NUM_PORTS;
      end
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = IDW'(idx);
      end
    end
  end

  // Round-robin start for the next arbitration: the port after the current owner.
  always_comb begin
    rr_d = (grant_q == LAST_ID) ? '0 : grant_q + IDW'(1);
  end

  // Ready is offered only to the arbitration winner in IDLE, or to the owner in
  // NEXT; it is withheld during reset because a byte cannot be captured then.
  always_comb begin
    req_ready = '0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            req_ready[win_idx] = 1'b1;
          end
        end
        ST_NEXT: begin
          req_ready[grant_q] = req_valid[grant_q];
        end
        default: begin
          req_ready = '0;
        end
      endcase
    end
  end

  // Arbitration FSM: grant in IDLE, present the buffered byte in LOAD, fetch the
  // owner's next byte (or time out) in NEXT.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      buf_data_q     <= '0;
      buf_last_q     <= 1'b0;
      grant_q        <= '0;
      rr_q           <= '0;
      tcnt_q         <= '0;
      lock_timeout_q <= 1'b0;
    end else begin
      lock_timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            buf_data_q <= port_byte[win_idx];
            buf_last_q <= req_last[win_idx];
            grant_q    <= win_idx;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (tx_ready) begin
            if (buf_last_q) begin
              state_q <= ST_IDLE;
              rr_q    <= rr_d;
            end else begin
              state_q <= ST_NEXT;
              tcnt_q  <= '0;
            end
          end
        end
        ST_NEXT: begin
          // A byte arriving on the boundary cycle takes priority over the timeout.
          if (req_valid[grant_q]) begin
            buf_data_q <= port_byte[grant_q];
            buf_last_q <= req_last[grant_q];
            state_q    <= ST_LOAD;
          end else if (tcnt_q == TCNT_LAST) begin
            state_q        <= ST_IDLE;
            lock_timeout_q <= 1'b1;
            rr_q           <= rr_d;
          end else begin
            tcnt_q <= tcnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_data           = buf_data_q;
  assign tx_data_available = (state_q == ST_LOAD);
  assign busy              = (state_q != ST_IDLE);
  assign grant_id          = grant_q;
  assign lock_timeout      = lock_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_tx_arbiter
//  Purpose  : Directed self-checking bench for serial_tx_arbiter with a
//             per-port message producer and a transmitter model (4 clk/bit).
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_tx_arbiter;

  localparam int NP      = 4;
  localparam int HT      = 16;
  localparam int CPB     = 4;
  localparam int TX_BITS = 10;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [NP*8-1:0] req_data = '0;
  logic [NP-1:0]   req_valid = '0;
  logic [NP-1:0]   req_last = '0;
  logic [NP-1:0]   req_ready;
  logic [7:0]      tx_data;
  logic            tx_data_available;
  logic            tx_ready = 1'b1;
  logic [1:0]      grant_id;
  logic            busy;
  logic            lock_timeout;

  // producer queues: {last, data}
  logic [8:0] pmem [NP][16];
  int         phead [NP];
  int         ptail [NP];

  logic [7:0] cap_log [64];
  int         ncap;
  int         nto;
  int         tx_busy;
  logic       stall;
  int         n_cmp;
  int         n_bad;

  always #5 clock = ~clock;

  serial_tx_arbiter #(.NUM_PORTS(NP), .HOLD_TIMEOUT(HT)) dut (
    .clock             (clock),
    .reset             (reset),
    .req_data          (req_data),
    .req_valid         (req_valid),
    .req_last          (req_last),
    .req_ready         (req_ready),
    .tx_data           (tx_data),
    .tx_data_available (tx_data_available),
    .tx_ready          (tx_ready),
    .grant_id          (grant_id),
    .busy              (busy),
    .lock_timeout      (lock_timeout)
  );

  task automatic drive_inputs();
    for (int i = 0; i < NP; i++) begin
      if (phead[i] < ptail[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = pmem[i][phead[i]][7:0];
        req_last[i]        = pmem[i][phead[i]][8];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic push(input int p, input logic [7:0] d, input logic l);
    pmem[p][ptail[p]] = {l, d};
    ptail[p]++;
    drive_inputs();
  endtask

  task automatic clear_queues();
    for (int i = 0; i < NP; i++) begin
      phead[i] = 0;
      ptail[i] = 0;
    end
    drive_inputs();
  endtask

  // one clock: sample handshakes at negedge, update producers/transmitter after posedge
  task automatic cycle();
    logic [NP-1:0] acc;
    logic          cap;
    @(negedge clock);
    acc = req_valid & req_ready;
    cap = tx_data_available && tx_ready && !reset;
    if (cap) begin
      cap_log[ncap] = tx_data;
      ncap++;
    end
    if (lock_timeout) nto++;
    @(posedge clock);
    #1;
    for (int i = 0; i < NP; i++) begin
      if (acc[i]) phead[i]++;
    end
    if (reset)            tx_busy = 0;
    else if (cap)         tx_busy = CPB * TX_BITS;
    else if (tx_busy > 0) tx_busy--;
    tx_ready = !stall && (tx_busy == 0);
    drive_inputs();
    #1;
  endtask

  task automatic wait_caps(input int n, input int budget);
    int k;
    k = 0;
    while (ncap < n && k < budget) begin
      cycle();
      k++;
    end
    n_cmp++;
    if (ncap < n) begin
      n_bad++;
      $display("FAIL wait_caps: got %0d captures, required %0d within %0d cycles", ncap, n, budget);
    end
  endtask

  task automatic reset_dut();
    reset   = 1'b1;
    stall   = 1'b0;
    tx_busy = 0;
    tx_ready = 1'b1;
    clear_queues();
    cycle();
    cycle();
    reset = 1'b0;
    ncap  = 0;
    nto   = 0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    stall   = 1'b0;
    tx_busy = 0;
    tx_ready = 1'b1;
    clear_queues();
    push(2, 8'h77, 1'b1);
    cycle();
    cycle();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_cmp++; if (tx_data_available !== 1'b0) begin n_bad++; $display("FAIL reset_avail: got %b, required 0", tx_data_available); end
    n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_txdata: got %h, required 00", tx_data); end
    n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL reset_grant: got %0d, required 0", grant_id); end
    n_cmp++; if (lock_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b, required 0", lock_timeout); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b, required 0000", req_ready); end
    reset = 1'b0;
    n_cmp++; if (tx_data_available !== 1'b0) begin n_bad++; $display("FAIL post_reset_avail: got %b, required 0", tx_data_available); end
    cycle();
    n_cmp++; if (tx_data_available !== 1'b1) begin n_bad++; $display("FAIL first_grant_avail: got %b, required 1", tx_data_available); end
    n_cmp++; if (grant_id !== 2'd2) begin n_bad++; $display("FAIL first_grant_id: got %0d, required 2", grant_id); end
    n_cmp++; if (tx_data !== 8'h77) begin n_bad++; $display("FAIL first_grant_data: got %h, required 77", tx_data); end
  endtask

  task automatic test_single();
    reset_dut();
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b0);
    push(0, 8'h43, 1'b1);
    wait_caps(2, 200);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_mid: got %b, required 1", busy); end
    wait_caps(3, 200);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end: got %b, required 0", busy); end
    n_cmp++; if (cap_log[0] !== 8'h41) begin n_bad++; $display("FAIL single_b0: got %h, required 41", cap_log[0]); end
    n_cmp++; if (cap_log[1] !== 8'h42) begin n_bad++; $display("FAIL single_b1: got %h, required 42", cap_log[1]); end
    n_cmp++; if (cap_log[2] !== 8'h43) begin n_bad++; $display("FAIL single_b2: got %h, required 43", cap_log[2]); end
    // rr_ptr now 1: port 1 must beat port 0
    push(0, 8'h10, 1'b1);
    push(1, 8'h11, 1'b1);
    wait_caps(5, 300);
    n_cmp++; if (cap_log[3] !== 8'h11) begin n_bad++; $display("FAIL single_rr_first: got %h, required 11", cap_log[3]); end
    n_cmp++; if (cap_log[4] !== 8'h10) begin n_bad++; $display("FAIL single_rr_second: got %h, required 10", cap_log[4]); end
  endtask

  task automatic test_contention();
    reset_dut();
    push(0, 8'h01, 1'b0);
    push(0, 8'h02, 1'b1);
    push(2, 8'h21, 1'b0);
    push(2, 8'h22, 1'b1);
    wait_caps(2, 200);
    n_cmp++; if (cap_log[0] !== 8'h01) begin n_bad++; $display("FAIL cont_b0: got %h, required 01", cap_log[0]); end
    n_cmp++; if (cap_log[1] !== 8'h02) begin n_bad++; $display("FAIL cont_b1: got %h, required 02", cap_log[1]); end
    n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL cont_grant0: got %0d, required 0", grant_id); end
    wait_caps(3, 200);
    n_cmp++; if (grant_id !== 2'd2) begin n_bad++; $display("FAIL cont_grant2: got %0d, required 2", grant_id); end
    n_cmp++; if (cap_log[2] !== 8'h21) begin n_bad++; $display("FAIL cont_b2: got %h, required 21", cap_log[2]); end
    wait_caps(4, 200);
    n_cmp++; if (cap_log[3] !== 8'h22) begin n_bad++; $display("FAIL cont_b3: got %h, required 22", cap_log[3]); end
  endtask

  task automatic test_fairness();
    logic [7:0] exp [5];
    exp[0] = 8'hA0; exp[1] = 8'hA1; exp[2] = 8'hA2; exp[3] = 8'hA3; exp[4] = 8'hA0;
    reset_dut();
    for (int i = 0; i < NP; i++) begin
      push(i, 8'hA0 + 8'(i), 1'b1);
      push(i, 8'hA0 + 8'(i), 1'b1);
    end
    wait_caps(5, 600);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (cap_log[i] !== exp[i]) begin
        n_bad++;
        $display("FAIL fair_order[%0d]: got %h, required %h", i, cap_log[i], exp[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int k;
    reset_dut();
    push(1, 8'h55, 1'b0);
    push(2, 8'h66, 1'b1);
    wait_caps(1, 50);
    n_cmp++; if (cap_log[0] !== 8'h55) begin n_bad++; $display("FAIL to_b0: got %h, required 55", cap_log[0]); end
    k = 0;
    while (lock_timeout !== 1'b1 && k < 40) begin
      cycle();
      k++;
    end
    n_cmp++; if (k != 16) begin n_bad++; $display("FAIL to_cycles: got %0d, required 16", k); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL to_busy: got %b, required 0", busy); end
    n_cmp++; if (grant_id !== 2'd1) begin n_bad++; $display("FAIL to_grant_hold: got %0d, required 1", grant_id); end
    cycle();
    n_cmp++; if (lock_timeout !== 1'b0) begin n_bad++; $display("FAIL to_pulse_width: got %b, required 0", lock_timeout); end
    n_cmp++; if (grant_id !== 2'd2) begin n_bad++; $display("FAIL to_next_grant: got %0d, required 2", grant_id); end
    wait_caps(2, 100);
    n_cmp++; if (cap_log[1] !== 8'h66) begin n_bad++; $display("FAIL to_b1: got %h, required 66", cap_log[1]); end
    repeat (60) cycle();
    n_cmp++; if (ncap != 2) begin n_bad++; $display("FAIL to_no_resume: got %0d captures, required 2", ncap); end
    n_cmp++; if (nto != 1) begin n_bad++; $display("FAIL to_pulse_count: got %0d, required 1", nto); end
    // boundary: byte arrives in the cycle where tcnt == HOLD_TIMEOUT-1
    reset_dut();
    push(1, 8'h71, 1'b0);
    wait_caps(1, 50);
    repeat (15) cycle();
    push(1, 8'h72, 1'b1);
    cycle();
    n_cmp++; if (lock_timeout !== 1'b0) begin n_bad++; $display("FAIL bnd_timeout: got %b, required 0", lock_timeout); end
    n_cmp++; if (tx_data_available !== 1'b1) begin n_bad++; $display("FAIL bnd_avail: got %b, required 1", tx_data_available); end
    n_cmp++; if (tx_data !== 8'h72) begin n_bad++; $display("FAIL bnd_data: got %h, required 72", tx_data); end
    wait_caps(2, 100);
    n_cmp++; if (cap_log[1] !== 8'h72) begin n_bad++; $display("FAIL bnd_b1: got %h, required 72", cap_log[1]); end
    n_cmp++; if (nto != 0) begin n_bad++; $display("FAIL bnd_pulse_count: got %0d, required 0", nto); end
  endtask

  task automatic test_stall();
    reset_dut();
    stall    = 1'b1;
    tx_ready = 1'b0;
    push(0, 8'h5A, 1'b1);
    cycle();
    push(1, 8'h5B, 1'b1);
    for (int i = 0; i < 50; i++) begin
      cycle();
      n_cmp++; if (tx_data_available !== 1'b1) begin n_bad++; $display("FAIL stall_avail[%0d]: got %b, required 1", i, tx_data_available); end
      n_cmp++; if (tx_data !== 8'h5A) begin n_bad++; $display("FAIL stall_data[%0d]: got %h, required 5a", i, tx_data); end
      n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL stall_ready[%0d]: got %b, required 0000", i, req_ready); end
    end
    n_cmp++; if (ncap != 0) begin n_bad++; $display("FAIL stall_nocap: got %0d captures, required 0", ncap); end
    stall    = 1'b0;
    tx_ready = (tx_busy == 0);
    cycle();
    n_cmp++; if (ncap != 1) begin n_bad++; $display("FAIL stall_one_cap: got %0d captures, required 1", ncap); end
    n_cmp++; if (cap_log[0] !== 8'h5A) begin n_bad++; $display("FAIL stall_b0: got %h, required 5a", cap_log[0]); end
    n_cmp++; if (tx_data_available !== 1'b0) begin n_bad++; $display("FAIL stall_avail_drop: got %b, required 0", tx_data_available); end
    wait_caps(2, 100);
    n_cmp++; if (cap_log[1] !== 8'h5B) begin n_bad++; $display("FAIL stall_b1: got %h, required 5b", cap_log[1]); end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    push(2, 8'h22, 1'b1);
    wait_caps(1, 50);
    push(3, 8'h33, 1'b0);
    push(3, 8'h34, 1'b1);
    cycle();
    n_cmp++; if (tx_data_available !== 1'b1) begin n_bad++; $display("FAIL rmid_avail_pre: got %b, required 1", tx_data_available); end
    n_cmp++; if (grant_id !== 2'd3) begin n_bad++; $display("FAIL rmid_grant_pre: got %0d, required 3", grant_id); end
    reset = 1'b1;
    cycle();
    n_cmp++; if (tx_data_available !== 1'b0) begin n_bad++; $display("FAIL rmid_avail: got %b, required 0", tx_data_available); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rmid_ready: got %b, required 0000", req_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b, required 0", busy); end
    push(1, 8'h11, 1'b1);
    reset = 1'b0;
    cycle();
    n_cmp++; if (grant_id !== 2'd1) begin n_bad++; $display("FAIL rmid_grant_post: got %0d, required 1", grant_id); end
    n_cmp++; if (tx_data !== 8'h11) begin n_bad++; $display("FAIL rmid_data_post: got %h, required 11", tx_data); end
    wait_caps(2, 50);
    n_cmp++; if (cap_log[1] !== 8'h11) begin n_bad++; $display("FAIL rmid_cap: got %h, required 11", cap_log[1]); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    ncap  = 0;
    nto   = 0;
    stall = 1'b0;
    tx_busy = 0;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_timeout();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
